hazard_stall_ctrl: RTL and testbench

//  Parametrised hazard/stall controller for the 5-stage MIPS pipeline; successor to the single-cycle detector.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/operand_use_decode.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Definitions shared by the pipeline control blocks: the MIPS opcodes that the
//   hazard and forwarding logic decode, the NOP encoding, and the state type of
//   the hazard/stall controller.
//   This package has no ports.
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // sll $0,$0,0 -- the all-zero word is the pipeline NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        BR_WAIT = 2'd2
    } hz_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/operand_use_decode.sv
// ----------------------------------------------------------------------------
// operand_use_decode
//   Tells, from the opcode alone, whether an instruction actually reads its rs
//   and rt fields. Lets hazard detection and forwarding ignore register fields
//   that merely hold immediates or destinations.
// Ports
//   op       in  6  opcode field [31:26] of the instruction
//   rs_used  out 1  instruction reads register rs
//   rt_used  out 1  instruction reads register rt
// ----------------------------------------------------------------------------
module operand_use_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    output logic       rs_used,
    output logic       rt_used
);

    // J/JAL carry a jump target and LUI an immediate where rs would sit.
    assign rs_used = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));

    // Only R-type, branches and stores read rt; in I-type ALU ops and loads
    // rt is the destination.
    assign rt_used = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Hazard/stall controller for the 5-stage MIPS pipeline. Inserts multi-cycle
//   load-use bubbles and post-branch NOP cycles, and counts stalled cycles.
// Ports
//   clk              in  1      pipeline clock, rising edge
//   rst_n            in  1      asynchronous active-low reset
//   id_ex_mem_read   in  1      instruction in EX is a load
//   id_ex_rt         in  REG_W  load destination in EX
//   ex_mem_mem_read  in  1      instruction in MEM is a load (MEM_LOAD_CHECK=1)
//   ex_mem_rt        in  REG_W  load destination in MEM
//   if_id_instr      in  32     instruction in ID
//   branch_resolved  in  1      branch unit updated the PC; ends branch stall
//   hold_pc          out 1      PC keeps its value
//   hold_if_id       out 1      IF/ID keeps its value
//   flush_if_id      out 1      IF/ID loads a NOP at the next edge
//   bubble_sel       out 1      ID/EX takes zeroed control
//   stall_cycles     out CNT_W  saturating count of cycles with hold_pc=1
// Handshake: none; all inputs are sampled as level signals every cycle.
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int REG_W          = 5,
    parameter int LOAD_STALLS    = 1,
    parameter int BRANCH_STALLS  = 1,
    parameter int MEM_LOAD_CHECK = 0,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             ex_mem_mem_read,
    input  logic [REG_W-1:0] ex_mem_rt,
    input  logic [31:0]      if_id_instr,
    input  logic             branch_resolved,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             flush_if_id,
    output logic             bubble_sel,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int  MAX_STALLS = max_int(LOAD_STALLS, BRANCH_STALLS);
    localparam int  CW         = $clog2(MAX_STALLS + 1);
    localparam bit  MEM_CHK_EN = (MEM_LOAD_CHECK != 0);
    localparam bit  BR_EN      = (BRANCH_STALLS > 0);

    // ---------------- decode ----------------
    logic [5:0]       op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             rs_used;
    logic             rt_used;
    logic             ex_match;
    logic             mem_match;
    logic             lu_hz;
    logic             br_hz;
    logic             unused_instr_bits;

    assign op = if_id_instr[31:26];
    assign rs = REG_W'(if_id_instr[25:21]);
    assign rt = REG_W'(if_id_instr[20:16]);
    assign unused_instr_bits = ^if_id_instr[15:0];

    operand_use_decode u_operand_use_decode (
        .op      (op),
        .rs_used (rs_used),
        .rt_used (rt_used)
    );

    // $zero never carries a dependency, whatever the load targets.
    assign ex_match  = (id_ex_rt != '0) &&
                       ((rs_used && (id_ex_rt == rs)) || (rt_used && (id_ex_rt == rt)));
    assign mem_match = (ex_mem_rt != '0) &&
                       ((rs_used && (ex_mem_rt == rs)) || (rt_used && (ex_mem_rt == rt)));

    assign lu_hz = (id_ex_mem_read && ex_match) || (MEM_CHK_EN && ex_mem_mem_read && mem_match);
    assign br_hz = BR_EN && ((op == OP_BEQ) || (op == OP_BNE));

    // ---------------- FSM ----------------
    hz_state_t     state;
    hz_state_t     state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          ld_stall;
    logic          br_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ld_stall   = 1'b0;
        br_stall   = 1'b0;
        case (state)
            IDLE: begin
                // Load-use first: a dependent branch must wait for its operand
                // before it may advance.
                if (lu_hz) begin
                    ld_stall = 1'b1;
                    if (LOAD_STALLS > 1) begin
                        state_next = LD_WAIT;
                        cnt_next   = CW'(LOAD_STALLS - 1);
                    end
                end else if (br_hz) begin
                    br_stall = 1'b1;
                    if ((BRANCH_STALLS > 1) && !branch_resolved) begin
                        state_next = BR_WAIT;
                        cnt_next   = CW'(BRANCH_STALLS - 1);
                    end
                end
            end
            LD_WAIT: begin
                ld_stall = 1'b1;
                cnt_next = cnt - 1'b1;
                // Back to IDLE, where the hazard is checked afresh.
                if (cnt == CW'(1)) begin
                    state_next = IDLE;
                end
            end
            BR_WAIT: begin
                br_stall = 1'b1;
                cnt_next = cnt - 1'b1;
                // The resolving cycle itself still stalls; release afterwards.
                if ((cnt == CW'(1)) || branch_resolved) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A load stall freezes IF/ID and bubbles EX; a branch stall lets the branch
    // move on and feeds NOPs in behind it. The two are exclusive by construction.
    assign hold_pc     = rst_n && (ld_stall || br_stall);
    assign hold_if_id  = rst_n && ld_stall;
    assign bubble_sel  = rst_n && ld_stall;
    assign flush_if_id = rst_n && br_stall;

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (hold_pc && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Two controller instances share one set of inputs:
//     A: LOAD_STALLS=1, BRANCH_STALLS=2, MEM_LOAD_CHECK=0, CNT_W=16
//     B: LOAD_STALLS=3, BRANCH_STALLS=1, MEM_LOAD_CHECK=1, CNT_W=4
//   A reference model tracks "load bubbles still owed" and "branch NOPs still
//   owed" per instance and is checked every cycle; directed scenarios pin it
//   with literal expectations, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int LS_A = 1, BS_A = 2, MLC_A = 0;
    localparam int LS_B = 3, BS_B = 1, MLC_B = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        id_ex_mem_read = 1'b0;
    logic [4:0]  id_ex_rt = '0;
    logic        ex_mem_mem_read = 1'b0;
    logic [4:0]  ex_mem_rt = '0;
    logic [31:0] if_id_instr = '0;
    logic        branch_resolved = 1'b0;

    logic        a_hold_pc, a_hold_if_id, a_flush, a_bubble;
    logic [15:0] a_cnt;
    logic        b_hold_pc, b_hold_if_id, b_flush, b_bubble;
    logic [3:0]  b_cnt;

    hazard_stall_ctrl #(.REG_W(5), .LOAD_STALLS(LS_A), .BRANCH_STALLS(BS_A),
                        .MEM_LOAD_CHECK(MLC_A), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rt(ex_mem_rt),
        .if_id_instr(if_id_instr), .branch_resolved(branch_resolved),
        .hold_pc(a_hold_pc), .hold_if_id(a_hold_if_id), .flush_if_id(a_flush),
        .bubble_sel(a_bubble), .stall_cycles(a_cnt)
    );

    hazard_stall_ctrl #(.REG_W(5), .LOAD_STALLS(LS_B), .BRANCH_STALLS(BS_B),
                        .MEM_LOAD_CHECK(MLC_B), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rt(ex_mem_rt),
        .if_id_instr(if_id_instr), .branch_resolved(branch_resolved),
        .hold_pc(b_hold_pc), .hold_if_id(b_hold_if_id), .flush_if_id(b_flush),
        .bubble_sel(b_bubble), .stall_cycles(b_cnt)
    );

    wire [3:0] a_outs = {a_hold_pc, a_hold_if_id, a_flush, a_bubble};
    wire [3:0] b_outs = {b_hold_pc, b_hold_if_id, b_flush, b_bubble};

    // {hold_pc, hold_if_id, flush_if_id, bubble_sel}
    localparam logic [3:0] O_LOAD = 4'b1101;
    localparam logic [3:0] O_BR   = 4'b1010;
    localparam logic [3:0] O_NONE = 4'b0000;

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int a_ld = 0, a_br = 0, a_sc = 0;
    int b_ld = 0, b_br = 0, b_sc = 0;

    function automatic bit reads_rs(input logic [5:0] op);
        return !(op == 6'd2 || op == 6'd3 || op == 6'd15);
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        return op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'd43;
    endfunction

    function automatic bit depends_on(input logic [4:0] r);
        logic [5:0] op;
        op = if_id_instr[31:26];
        return (r != 5'd0) && ((reads_rs(op) && r == if_id_instr[25:21]) ||
                               (reads_rt(op) && r == if_id_instr[20:16]));
    endfunction

    function automatic bit load_use(input int mlc);
        return (id_ex_mem_read && depends_on(id_ex_rt)) ||
               (mlc != 0 && ex_mem_mem_read && depends_on(ex_mem_rt));
    endfunction

    function automatic bit is_branch(input int bs);
        return bs > 0 && (if_id_instr[31:26] == 6'd4 || if_id_instr[31:26] == 6'd5);
    endfunction

    function automatic logic [3:0] model_out(input int mlc, input int bs, input int ld, input int br);
        if (!rst_n)        return O_NONE;
        if (ld > 0)        return O_LOAD;
        if (br > 0)        return O_BR;
        if (load_use(mlc)) return O_LOAD;
        if (is_branch(bs)) return O_BR;
        return O_NONE;
    endfunction

    // Owed-cycle bookkeeping: a new load hazard owes ls-1 further bubbles, a
    // new branch owes bs-1 further NOPs unless already resolved; a resolve
    // while owing NOPs cancels the rest after the current one.
    task automatic advance(input int ls, input int bs, input int mlc,
                           input int ld_i, input int br_i, output int ld_o, output int br_o);
        ld_o = ld_i;
        br_o = br_i;
        if (ld_i > 0)              ld_o = ld_i - 1;
        else if (br_i > 0)         br_o = branch_resolved ? 0 : br_i - 1;
        else if (load_use(mlc))    ld_o = ls - 1;
        else if (is_branch(bs))    br_o = branch_resolved ? 0 : bs - 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        int nl, nb;
        if (!rst_n) begin
            a_ld = 0; a_br = 0; a_sc = 0;
            b_ld = 0; b_br = 0; b_sc = 0;
        end else begin
            if (model_out(MLC_A, BS_A, a_ld, a_br) & 4'b1000) a_sc = (a_sc < 65535) ? a_sc + 1 : 65535;
            if (model_out(MLC_B, BS_B, b_ld, b_br) & 4'b1000) b_sc = (b_sc < 15) ? b_sc + 1 : 15;
            advance(LS_A, BS_A, MLC_A, a_ld, a_br, nl, nb);
            a_ld = nl; a_br = nb;
            advance(LS_B, BS_B, MLC_B, b_ld, b_br, nl, nb);
            b_ld = nl; b_br = nb;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] ea, eb;
        ea = model_out(MLC_A, BS_A, a_ld, a_br);
        eb = model_out(MLC_B, BS_B, b_ld, b_br);
        check("model_a", {12'd0, a_outs, a_cnt}, {12'd0, ea, 16'(a_sc)});
        check("model_b", {24'd0, b_outs, b_cnt}, {24'd0, eb, 4'(b_sc)});
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rt, input logic [31:0] instr, input logic res);
        id_ex_mem_read  = mr;
        id_ex_rt        = rt;
        if_id_instr     = instr;
        branch_resolved = res;
    endtask

    localparam logic [31:0] ADD_RS8   = {6'd0, 5'd8, 5'd9, 5'd10, 11'd0};
    localparam logic [31:0] ADD_ZERO  = {6'd0, 5'd0, 5'd0, 5'd3, 11'd0};
    localparam logic [31:0] ADDI_RT9  = {6'b001000, 5'd1, 5'd9, 16'd5};
    localparam logic [31:0] BEQ_1_2   = {6'd4, 5'd1, 5'd2, 16'd3};
    localparam logic [31:0] BEQ_9_0   = {6'd4, 5'd9, 5'd0, 16'd1};

    logic [5:0] op_tab [9] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd15, 6'd43, 6'd35, 6'd8};

    // ---------------- stimulus ----------------
    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("reset_a", {12'd0, a_outs, a_cnt}, 32'd0);
        check("reset_b", {24'd0, b_outs, b_cnt}, 32'd0);
        #2 rst_n = 1'b1;
        next_cycle();

        // load-use: add reads $8 which the load in EX writes
        drive(1'b1, 5'd8, ADD_RS8, 1'b0);
        @(negedge clk);
        check("lu1_a_c1", {28'd0, a_outs}, {28'd0, O_LOAD});
        check("lu3_b_c1", {28'd0, b_outs}, {28'd0, O_LOAD});
        next_cycle();
        drive(1'b0, 5'd8, ADD_RS8, 1'b0);   // bubble now in EX
        @(negedge clk);
        check("lu1_a_c2", {28'd0, a_outs}, {28'd0, O_NONE});
        check("lu3_b_c2", {28'd0, b_outs}, {28'd0, O_LOAD});
        next_cycle();
        @(negedge clk);
        check("lu3_b_c3", {28'd0, b_outs}, {28'd0, O_LOAD});
        next_cycle();
        @(negedge clk);
        check("lu3_b_c4", {28'd0, b_outs}, {28'd0, O_NONE});
        check("lu3_b_cnt", {28'd0, b_cnt}, 32'd3);
        check("lu1_a_cnt", {16'd0, a_cnt}, 32'd1);

        // $zero and unused rt never stall
        next_cycle();
        drive(1'b1, 5'd0, ADD_ZERO, 1'b0);
        @(negedge clk);
        check("zero_reg", {24'd0, a_outs, b_outs}, 32'd0);
        next_cycle();
        drive(1'b1, 5'd9, ADDI_RT9, 1'b0);
        @(negedge clk);
        check("rt_unused", {24'd0, a_outs, b_outs}, 32'd0);

        // branch: A flushes 2 cycles, B 1 cycle
        next_cycle();
        drive(1'b0, 5'd0, BEQ_1_2, 1'b0);
        @(negedge clk);
        check("br_c1", {24'd0, a_outs, b_outs}, {24'd0, O_BR, O_BR});
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("br_c2", {24'd0, a_outs, b_outs}, {24'd0, O_BR, O_NONE});
        next_cycle();
        @(negedge clk);
        check("br_c3_a", {28'd0, a_outs}, {28'd0, O_NONE});

        // early release in the first branch cycle
        next_cycle();
        drive(1'b0, 5'd0, BEQ_1_2, 1'b1);
        @(negedge clk);
        check("br_early_c1", {28'd0, a_outs}, {28'd0, O_BR});
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("br_early_c2", {28'd0, a_outs}, {28'd0, O_NONE});

        // load feeding a BEQ: bubble first, then branch NOPs
        next_cycle();
        drive(1'b1, 5'd9, BEQ_9_0, 1'b0);
        @(negedge clk);
        check("ldbr_c1", {28'd0, a_outs}, {28'd0, O_LOAD});
        next_cycle();
        drive(1'b0, 5'd9, BEQ_9_0, 1'b0);
        @(negedge clk);
        check("ldbr_c2", {28'd0, a_outs}, {28'd0, O_BR});
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("ldbr_c3", {28'd0, a_outs}, {28'd0, O_BR});
        next_cycle();
        @(negedge clk);
        check("ldbr_c4", {28'd0, a_outs}, {28'd0, O_NONE});

        // asynchronous reset while B sits in its multi-cycle load stall
        next_cycle();
        drive(1'b1, 5'd8, ADD_RS8, 1'b0);
        next_cycle();
        drive(1'b0, 5'd8, ADD_RS8, 1'b0);
        #1;
        check("rst_pre_b", {31'd0, b_hold_pc}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_b", {24'd0, b_outs, b_cnt}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_after_b", {24'd0, b_outs, b_cnt}, 32'd0);

        // persistent hazard: B's 4-bit counter saturates, A keeps counting
        next_cycle();
        drive(1'b1, 5'd8, ADD_RS8, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("sat_b", {28'd0, b_cnt}, 32'd15);
        check("count_a", {16'd0, a_cnt}, 32'd20);
        drive(1'b0, 5'd0, 32'd0, 1'b0);

        // randomized run with occasional resets
        repeat (3000) begin
            next_cycle();
            id_ex_mem_read  = ($urandom_range(0, 1) == 1);
            id_ex_rt        = 5'($urandom_range(0, 3));
            ex_mem_mem_read = ($urandom_range(0, 1) == 1);
            ex_mem_rt       = 5'($urandom_range(0, 3));
            branch_resolved = ($urandom_range(0, 3) == 0);
            if_id_instr     = {op_tab[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                               5'($urandom_range(0, 3)), 16'($urandom)};
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

        next_cycle();
        ex_mem_mem_read = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
